// File: rtl/median_pkg.sv
// ---------------------------------------------------------------------------
// median_pkg
//   Shared definitions for the 3x3 median filter: the window builder and the
//   downstream median network both use these.
//   Contents:
//     PIX_MSB / PIX_W      default pixel MSB index and pixel width
//     IMG_W_DEF/IMG_H_DEF  default frame geometry (pixels per line, lines)
//     W00..W22             flat index of window element w[r][c] (3*r+c);
//                          r0 = oldest row, c0 = leftmost column
//     pix_t / win_t        pixel and packed 3x3 window at the default width;
//                          win_t[3*r+c] is w[r][c]
// ---------------------------------------------------------------------------
package median_pkg;

  localparam int PIX_MSB   = 15;
  localparam int PIX_W     = PIX_MSB + 1;
  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;

  localparam int W00 = 0;
  localparam int W01 = 1;
  localparam int W02 = 2;
  localparam int W10 = 3;
  localparam int W11 = 4;
  localparam int W12 = 5;
  localparam int W20 = 6;
  localparam int W21 = 7;
  localparam int W22 = 8;

  typedef logic [PIX_MSB:0]  pix_t;
  typedef logic [8:0][PIX_MSB:0] win_t;

endpackage

// File: rtl/median_win_3x3_line_buf_ram.sv
// ---------------------------------------------------------------------------
// line_buf_ram
//   One line of pixel storage for the 3x3 window builder. Simple dual-port:
//   one synchronous write port, one asynchronous read port. A read and a
//   write to the same address in the same cycle return the old contents
//   (read-before-write), which is what lets the window builder read the
//   previous line at column c while overwriting column c with the new line.
//   Contents are not reset.
//   Ports:
//     clk        in   write clock, rising edge
//     i_wr_en    in   write enable
//     i_wr_addr  in   write address (column)
//     i_wr_data  in   write data (pixel)
//     i_rd_addr  in   read address (column)
//     o_rd_data  out  read data, combinational from i_rd_addr
// ---------------------------------------------------------------------------
module line_buf_ram
  import median_pkg::*;
#(
  parameter int DEPTH = IMG_W_DEF,
  parameter int WIDTH = PIX_W
) (
  input  logic                     clk,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [WIDTH-1:0]         o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // The write lands on the clock edge, so the combinational read always sees
  // the value from before that edge.
  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/median_win_3x3.sv
// ---------------------------------------------------------------------------
// median_win_3x3
//   Builds a sliding 3x3 pixel window from a raster-order pixel stream for
//   the 3x3 median stage. Two line buffers hold the previous two lines; a
//   3-column shift register holds the window. One window is emitted per
//   accepted pixel once the window lies fully inside the frame.
//   Parameters:
//     size   pixel MSB index (pixel width = size+1)
//     IMG_W  pixels per line (>=3)
//     IMG_H  lines per frame (>=3)
//   Ports:
//     clk        in   single clock, rising edge
//     rst_n      in   asynchronous, active-low reset
//     in_valid   in   in_pix valid this cycle (no backpressure)
//     in_pix     in   pixel, raster order
//     sof        in   start-of-frame marker (only with SOF_SYNC_EN defined)
//     win_valid  out  win holds a complete in-frame window
//     win        out  w[r][c] at win[(3*r+c)*(size+1) +: size+1]
//     win_eof    out  qualifies the last window of the frame
//   Build option:
//     SOF_SYNC_EN  adds the sof input; an accepted pixel with sof=1 is taken
//                  as pixel (0,0) of a new frame.
// ---------------------------------------------------------------------------
module median_win_3x3
  import median_pkg::*;
#(
  parameter int size  = PIX_MSB,
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [size:0]       in_pix,
`ifdef SOF_SYNC_EN
  input  logic                sof,
`endif
  output logic                win_valid,
  output logic [9*(size+1)-1:0] win,
  output logic                win_eof
);

  localparam int PW    = size + 1;
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] w_col;
  logic [ROW_W-1:0] w_row;
  logic             w_sof;
  logic             w_last_col;
  logic             w_last_row;
  logic [PW-1:0]    w_lb1_rd;
  logic [PW-1:0]    w_lb2_rd;

  // Window storage indexed [row][col]; packed so that flattening gives
  // element (3*r+c), matching the output layout directly.
  logic [2:0][2:0][PW-1:0] r_win;
  logic                    r_win_valid;
  logic                    r_win_eof;

`ifdef SOF_SYNC_EN
  assign w_sof = sof;
`else
  assign w_sof = 1'b0;
`endif

  // Effective position of the pixel being offered: a start-of-frame marker
  // overrides the counters so the pixel is treated as (0,0).
  always_comb begin
    w_col      = r_col;
    w_row      = r_row;
    if (w_sof) begin
      w_col = '0;
      w_row = '0;
    end
    w_last_col = (w_col == COL_W'(IMG_W - 1));
    w_last_row = (w_row == ROW_W'(IMG_H - 1));
  end

  // lb1 holds the previous line; lb2 is fed from lb1 so it always holds the
  // line before that.
  line_buf_ram #(.DEPTH(IMG_W), .WIDTH(PW)) u_lb1 (
    .clk       (clk),
    .i_wr_en   (in_valid),
    .i_wr_addr (w_col),
    .i_wr_data (in_pix),
    .i_rd_addr (w_col),
    .o_rd_data (w_lb1_rd)
  );

  line_buf_ram #(.DEPTH(IMG_W), .WIDTH(PW)) u_lb2 (
    .clk       (clk),
    .i_wr_en   (in_valid),
    .i_wr_addr (w_col),
    .i_wr_data (w_lb1_rd),
    .i_rd_addr (w_col),
    .o_rd_data (w_lb2_rd)
  );

  // Raster position counters; both wrap at the end of the frame so frames
  // run back-to-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (in_valid) begin
      if (w_last_col) begin
        r_col <= '0;
        r_row <= w_last_row ? '0 : w_row + ROW_W'(1);
      end else begin
        r_col <= w_col + COL_W'(1);
        r_row <= w_row;
      end
    end
  end

  // Window shift register plus qualifiers. Columns are not flushed at line
  // start: windows straddling two lines are simply never flagged valid,
  // because the column gate needs col>=2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win       <= '0;
      r_win_valid <= 1'b0;
      r_win_eof   <= 1'b0;
    end else begin
      r_win_valid <= 1'b0;
      r_win_eof   <= 1'b0;
      if (in_valid) begin
        for (int r = 0; r < 3; r++) begin
          r_win[r][0] <= r_win[r][1];
          r_win[r][1] <= r_win[r][2];
        end
        r_win[0][2] <= w_lb2_rd;
        r_win[1][2] <= w_lb1_rd;
        r_win[2][2] <= in_pix;
        r_win_valid <= !w_sof && (w_row >= ROW_W'(2)) && (w_col >= COL_W'(2));
        r_win_eof   <= !w_sof && w_last_row && w_last_col;
      end
    end
  end

  assign win       = r_win;
  assign win_valid = r_win_valid;
  assign win_eof   = r_win_eof;

endmodule
